// File: rtl/dffram_port_arbiter_pkg.sv
// Shared definitions for the DFF RAM port arbiter: default bus widths,
// arbiter state encoding and a pointer-width helper.
package dffram_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Round-robin pointer width; never drops below one bit so a 1- or
  // 2-requester arbiter still has a usable pointer register.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dffram_port_arbiter_if.sv
// Requester-side bus of the DFF RAM port arbiter. The requesters (pin
// bridge, CPU load/store unit) use the master modport, the arbiter the
// slave modport. Per-requester fields are packed, requester i at slice i.
interface dffram_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dffram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the request mask starting one
// position after the pointer and wrapping modulo N, returning a one-hot
// grant, the winner index and an any-grant flag.
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     mask_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  // First set mask bit at ptr+1, ptr+2, ... (mod N) wins.
  always_comb begin
    int   cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && mask_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = PTR_W'(cand);
        found         = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/dffram_port_arbiter.sv
// Shares the single-port DFF RAM macro between NUM_REQ requesters with
// round-robin arbitration, an optional bounded burst lock, and routing of
// read data back to the requester that issued the read.
module dffram_port_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dffram_port_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e         state_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]   lock_cnt_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   win_idx;
  logic               accept;
  logic               win_we;
  logic               win_lock;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  logic [RD_LATENCY-1:0] rsp_v_q;
  logic [PTR_W-1:0]      rsp_id_q [RD_LATENCY];
  logic                  tail_v;

  // Eligible requesters: everyone when idle, only the owner while locked
  // (an absent owner yields an empty mask, i.e. the release bubble).
  always_comb begin
    mask = '0;
    if (rst_n) begin
      if (state_q == ARB_IDLE) begin
        mask = bus.req_valid;
      end else begin
        mask = bus.req_valid & (NUM_REQ'(1) << owner_q);
      end
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .mask_i  (mask),
    .ptr_i   (last_grant_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (accept)
  );

  assign bus.req_ready = grant;

  // Winner's request fields, and the RAM-side drive that holds the last
  // address/data whenever nothing is accepted.
  always_comb begin
    win_we    = bus.req_we[win_idx];
    win_lock  = bus.req_lock[win_idx];
    win_addr  = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_wdata = bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
    addr_d    = accept ? win_addr  : addr_q;
    wdata_d   = accept ? win_wdata : wdata_q;
    ram_we    = accept & win_we;
    ram_addr  = rst_n ? addr_d  : '0;
    ram_wdata = rst_n ? wdata_d : '0;
  end

  // Hold registers for the RAM address/data between accepted transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Arbiter FSM: round-robin pointer, lock owner and burst length counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      lock_cnt_q   <= '0;
      last_grant_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        last_grant_q <= win_idx;
      end
      case (state_q)
        ARB_IDLE: begin
          if (accept && win_lock && (LOCK_MAX > 1)) begin
            state_q    <= ARB_LOCKED;
            owner_q    <= win_idx;
            lock_cnt_q <= CNT_W'(1);
          end
        end
        ARB_LOCKED: begin
          if (!bus.req_valid[owner_q]) begin
            state_q    <= ARB_IDLE;
            lock_cnt_q <= '0;
          end else if (accept) begin
            if (win_lock && ((lock_cnt_q + 1'b1) != CNT_W'(LOCK_MAX))) begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end else begin
              state_q    <= ARB_IDLE;
              lock_cnt_q <= '0;
            end
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  // Read-response tracker: {valid, id} delayed by the macro read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_v_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rsp_id_q[i] <= '0;
      end
    end else begin
      rsp_v_q[0]  <= accept & ~win_we;
      rsp_id_q[0] <= win_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rsp_v_q[i]  <= rsp_v_q[i-1];
        rsp_id_q[i] <= rsp_id_q[i-1];
      end
    end
  end

  assign tail_v        = rst_n & rsp_v_q[RD_LATENCY-1];
  assign bus.rsp_valid = tail_v ? (NUM_REQ'(1) << rsp_id_q[RD_LATENCY-1]) : '0;
  assign bus.rsp_rdata = tail_v ? ram_rdata : '0;

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// Bench for dffram_port_arbiter: directed per-cycle vectors with
// hand-computed grants, plus a RAM macro model and a response scoreboard.
module tb_dffram_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 1;
  localparam int LOCKMAX = 16;

  typedef struct {
    int             due;
    int             id;
    logic [7:0]     data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  rsp_t expQ[$];
  rsp_t monE;
  logic [ADDR_W-1:0] lastAddr = '0;
  logic [DATA_W-1:0] lastWdata = '0;

  logic [7:0] mem [128] = '{default: 8'h00};
  logic [7:0] rdPipe [RD_LAT];
  logic       preloaded = 1'b0;

  dffram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dffram_port_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LAT),
    .LOCK_MAX   (LOCKMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM macro model: synchronous write, read data RD_LAT cycles after address.
  always @(posedge clk) begin
    if (!preloaded) begin
      mem[8'h10] <= 8'h11;
      mem[8'h20] <= 8'h22;
      preloaded  <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rdPipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign ram_rdata = rdPipe[RD_LAT-1];

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", what, cyc, act, exp);
    end
  endtask

  // Drive one cycle of requests and check the grant and RAM-side drive.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                               input logic [6:0] a0, input logic [6:0] a1,
                               input logic [7:0] w0, input logic [7:0] w1,
                               input logic [1:0] expRdy, input logic [7:0] expData,
                               input bit rspKept, input string name);
    int   idx;
    logic expWe;
    rsp_t e;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lk;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {w1, w0};
    idx   = expRdy[1] ? 1 : 0;
    expWe = (expRdy != 2'b00) && we[idx];
    if (expRdy != 2'b00) begin
      lastAddr  = idx ? a1 : a0;
      lastWdata = idx ? w1 : w0;
      if (!we[idx] && rspKept) begin
        e.due  = cyc + RD_LAT;
        e.id   = idx;
        e.data = expData;
        expQ.push_back(e);
      end
    end
    #3;
    checkOutput({name, ".req_ready"}, 32'(bus.req_ready), 32'(expRdy));
    checkOutput({name, ".ram_we"},    32'(ram_we),        32'(expWe));
    checkOutput({name, ".ram_addr"},  32'(ram_addr),      32'(lastAddr));
    checkOutput({name, ".ram_wdata"}, 32'(ram_wdata),     32'(lastWdata));
  endtask

  // One reset cycle with a live request; nothing may be granted.
  task automatic resetCycle();
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b00;
    bus.req_lock  = 2'b11;
    lastAddr      = '0;
    lastWdata     = '0;
    #3;
    checkOutput("reset.req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("reset.ram_we",    32'(ram_we),        32'h0);
    checkOutput("reset.rsp_valid", 32'(bus.rsp_valid), 32'h0);
  endtask

  // Scoreboard monitor: every response must match the oldest expectation,
  // on exactly the expected cycle; overdue expectations are failures.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].due < cyc) begin
      monE = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL rsp_missing: id %0d due cycle %0d, got none", monE.id, monE.due);
    end
    if (bus.rsp_valid != '0) begin
      if (expQ.size() == 0 || expQ[0].due != cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_unexpected (cycle %0d): got rsp_valid 0x%0h, expected none",
                 cyc, bus.rsp_valid);
      end else begin
        monE = expQ.pop_front();
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(1) << monE.id);
        checkOutput("rsp_rdata", 32'(bus.rsp_rdata), 32'(monE.data));
      end
    end
  end

  initial begin
    int budget;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    resetCycle();
    resetCycle();

    // write then read back through requester 0
    applyStimulus(2'b01, 2'b01, 2'b00, 7'h05, 7'h20, 8'hA5, 8'h00, 2'b01, 8'h00, 1'b1, "wr05");
    applyStimulus(2'b01, 2'b00, 2'b00, 7'h05, 7'h20, 8'h00, 8'h00, 2'b01, 8'hA5, 1'b1, "rd05");
    applyStimulus(2'b00, 2'b00, 2'b00, 7'h05, 7'h20, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1, "idle_hold");

    // single requester wins regardless of pointer
    applyStimulus(2'b10, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b10, 8'h22, 1'b1, "solo1");

    // both valid: alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00,
                    (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'h11 : 8'h22, 1'b1, "alt");
    end
    applyStimulus(2'b11, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b01, 8'h11, 1'b1, "alt_last");

    // requester 1 locks for 3 reads, releases on a lock=0 transfer
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b10, 7'h10, 7'h20, 8'h00, 8'h00, 2'b10, 8'h22, 1'b1, "lock3");
    end
    applyStimulus(2'b11, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b10, 8'h22, 1'b1, "unlock");
    applyStimulus(2'b11, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b01, 8'h11, 1'b1, "after_unlock");

    // lock held forever: forced release after LOCKMAX transfers
    for (int i = 0; i < LOCKMAX; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b10, 7'h10, 7'h20, 8'h00, 8'h00, 2'b10, 8'h22, 1'b1, "lockmax");
    end
    applyStimulus(2'b11, 2'b00, 2'b10, 7'h10, 7'h20, 8'h00, 8'h00, 2'b01, 8'h11, 1'b1, "forced_release");
    applyStimulus(2'b00, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1, "idle2");

    // locked owner drops valid: one bubble, then req0 from pointer=owner
    applyStimulus(2'b10, 2'b00, 2'b10, 7'h10, 7'h20, 8'h00, 8'h00, 2'b10, 8'h22, 1'b1, "lock_own");
    applyStimulus(2'b01, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1, "bubble");
    applyStimulus(2'b11, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b01, 8'h11, 1'b1, "resume");

    // write from requester 1, read back from requester 0
    applyStimulus(2'b10, 2'b10, 2'b00, 7'h10, 7'h30, 8'h00, 8'h5A, 2'b10, 8'h00, 1'b1, "wr30");
    applyStimulus(2'b01, 2'b00, 2'b00, 7'h30, 7'h20, 8'h00, 8'h00, 2'b01, 8'h5A, 1'b1, "rd30");

    // read accepted, then reset: its response must never appear
    applyStimulus(2'b01, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b01, 8'h11, 1'b0, "rd_killed");
    resetCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1, "post_reset");
    checkOutput("post_reset.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("post_reset.rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    applyStimulus(2'b11, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b01, 8'h11, 1'b1, "first_after_reset");
    applyStimulus(2'b00, 2'b00, 2'b00, 7'h10, 7'h20, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1, "tail");

    budget = 0;
    while (expQ.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("drain.pending", 32'(expQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dffram_port_arbiter.md
Name: dffram_port_arbiter

Overview:
- Shares the single-port 128x8 DFF RAM macro (7-bit address, write-enable, 8-bit write/read data) between NUM_REQ independent requesters.
- Round-robin arbitration with per-request valid/ready handshake and optional burst lock.
- Read data is routed back to the originating requester after the macro's fixed read latency.
- Sits between the RAM macro and the on-chip masters: the external pin bridge and the CPU load/store unit.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 7, RAM address width
DATA_W, 8, RAM data width
RD_LATENCY, 1, cycles from the accepted read to valid ram_rdata (1..3)
LOCK_MAX, 16, maximum consecutive accepted transfers under one lock before forced release

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  in  NUM_REQ  request valid per requester
req_we  in  NUM_REQ  1=write, 0=read
req_lock  in  NUM_REQ  hold the grant after this transfer
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot or zero; transfer accepted when valid&ready
rsp_valid  out  NUM_REQ  one-cycle pulse, read data for requester i
rsp_rdata  out  DATA_W  read data, shared, qualified by rsp_valid
ram_addr  out  ADDR_W  to RAM macro
ram_we  out  1  to RAM macro
ram_wdata  out  DATA_W  to RAM macro
ram_rdata  in  DATA_W  from RAM macro

Behaviour:
- At most one transfer is accepted per cycle. req_ready is combinational from req_valid and state, and never depends on req_ready itself.
- Round-robin pointer last_grant resets to NUM_REQ-1, so requester 0 wins first. Search order is last_grant+1, +2, ... mod NUM_REQ. last_grant updates to the winner on every accepted transfer.
- ram_addr/ram_we/ram_wdata are driven from the winner in the same cycle.
- ram_we = valid&ready&we of the winner. It is 0 when nothing is accepted; addr and wdata then hold the last values.
- Read accepted in cycle T:
  - rsp_valid[i]=1 and rsp_rdata=ram_rdata in cycle T+RD_LATENCY.
  - Tracked by a RD_LATENCY-deep shift register of {valid, id}.
  - Back-to-back reads are fully pipelined at throughput 1/cycle.
- Writes produce no response.
- FSM states:
  - IDLE: round-robin over all requesters.
  - LOCKED(owner): only the owner can get ready; all others see ready=0.
- IDLE->LOCKED: on an accepted transfer with req_lock=1. lock_cnt is set to 1.
- LOCKED, owner accepted with lock=1: lock_cnt increments.
  - If lock_cnt reaches LOCK_MAX on this transfer, go to IDLE. The forced release is fair: last_grant=owner.
- LOCKED, owner accepted with lock=0: go to IDLE after this transfer.
- LOCKED, owner req_valid=0: go to IDLE next cycle. No other requester is granted in that cycle (one idle bubble).
- Simultaneous requests in IDLE: the pointer order decides. A single valid requester always wins regardless of the pointer.
- Reset values:
  - req_ready=0 during reset.
  - rsp_valid=0, rsp_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - state=IDLE, lock_cnt=0, last_grant=NUM_REQ-1.
- Reset mid-operation: in-flight read responses are discarded (pipeline cleared) and any lock is dropped.
- Width rules: lock_cnt is clog2(LOCK_MAX+1) bits and saturates only via release. The pointer is clog2(NUM_REQ) bits with explicit mod wrap.

Decomposition:
- Package dffram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum {ARB_IDLE, ARB_LOCKED}.
  - Function clog2-safe pointer width.
- Sub-module rr_pick: combinational round-robin picker, inputs mask and pointer, output one-hot grant plus index. Reused by later bus arbiters.
- The response shift register stays inline.

Test Plan:
- Reset then req0 write addr 0x05 data 0xA5, then req0 read 0x05 -> ram_we=1 one cycle; rsp_valid[0]=1 with rsp_rdata=0xA5 exactly RD_LATENCY cycles after read accept.
- Both requesters continuously valid reading 0x10 (req0) and 0x20 (req1) -> grants alternate 0,1,0,1 starting with 0; each rsp_valid pulse carries the matching id.
- req1 lock=1 for 3 reads, req0 valid throughout -> req0 ready=0 for those 3 cycles; req0 granted on the cycle after req1 drops lock.
- LOCK_MAX=16, req1 holds lock and valid forever with req0 valid -> exactly 16 req1 transfers, then req0 granted next.
- Read accepted, rst_n=0 in the next cycle -> no rsp_valid emerges; all outputs zero after the reset edge; first post-reset grant goes to req0.
- Locked owner deasserts valid -> one cycle with all ready=0, then round-robin resumes from last_grant=owner.
